// File: rtl/seg_shift_pipe_if.sv
// seg_shift_pipe_if.sv
// Format enum shared by the shifter and its users, plus the beat interface
// that carries the input beat (fmt/X/S/in_tag with in_valid/in_ready) and the
// result (R/stickies/out_tag with out_valid/out_ready).
//   master : producer of input beats / consumer of results (testbench, upstream)
//   slave  : the shifter itself
package seg_shift_pkg;
  typedef enum logic [1:0] {
    FMT_FP32   = 2'd0,
    FMT_FP16X2 = 2'd1,
    FMT_BF16X2 = 2'd2
  } fp_fmt_e;
endpackage

interface seg_shift_if
  import seg_shift_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int S_W    = 8,
  parameter int TAG_W  = 4
);
  fp_fmt_e           fmt;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] X;
  logic [S_W-1:0]    S;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W+1:0] R;
  logic              Sticky_h;
  logic              Sticky_l;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output fmt, in_valid, X, S, in_tag, out_ready,
    input  in_ready, out_valid, R, Sticky_h, Sticky_l, out_tag
  );

  modport slave (
    input  fmt, in_valid, X, S, in_tag, out_ready,
    output in_ready, out_valid, R, Sticky_h, Sticky_l, out_tag
  );
endinterface

// File: rtl/seg_shift_pipe.sv
// seg_shift_pipe.sv
// Pipelined right shifter for the shared FP32 / dual-half fraction datapath
// (exponent alignment ahead of the adder). FP32 mode shifts one DATA_W+2 lane;
// split mode shifts two independent LANE_W+2 lanes packed at the top and
// bottom of the word with a zero gap between them. Each lane reports a sticky
// bit (OR of everything shifted out).
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset, drops all in-flight beats
//   bus  - seg_shift_if.slave: input beat (fmt, X, S, in_tag, in_valid/in_ready)
//          and result (R, Sticky_h, Sticky_l, out_tag, out_valid/out_ready)
module seg_shift_pipe
  import seg_shift_pkg::*;
#(
  parameter int DATA_W       = 24,
  parameter int LANE_W       = 8,
  parameter int SHAMT_W      = 5,
  parameter int LANE_SHAMT_W = 4,
  parameter int S_W          = 8,
  parameter int PIPE_STAGES  = 2,
  parameter int TAG_W        = 4
) (
  input  logic       clk,
  input  logic       rst,
  seg_shift_if.slave bus
);

  localparam int WW  = DATA_W + 2;
  localparam int LW2 = LANE_W + 2;
  // Number of log-shifter stages: enough for the wider of the two shift fields.
  localparam int K   = (SHAMT_W > LANE_SHAMT_W) ? SHAMT_W : LANE_SHAMT_W;

  // Shift fields are zero-extended to K bits so every stage can index them.
  typedef struct packed {
    logic             fp32;
    logic [WW-1:0]    w;
    logic [K-1:0]     sh_f;
    logic [K-1:0]     sh_h;
    logic [K-1:0]     sh_l;
    logic             st_h;
    logic             st_l;
    logic [TAG_W-1:0] tag;
  } beat_t;

  // Rank i sits after stage floor(i*K/PIPE_STAGES); the last rank is always
  // after the final stage, so the outputs come straight from registers.
  function automatic bit is_rank(input int k);
    for (int i = 1; i <= PIPE_STAGES; i++)
      if ((i * K) / PIPE_STAGES == k + 1) return 1'b1;
    return 1'b0;
  endfunction

  logic                   adv;
  logic [PIPE_STAGES:1]   vld_q;
  logic [PIPE_STAGES:0]   vld_pipe;
  beat_t                  n_in;
  beat_t                  node [0:K];

  // Global stall: every rank moves together, bubbles included.
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;
  assign vld_pipe     = {vld_q, bus.in_valid};

  always_ff @(posedge clk) begin
    if (rst)      vld_q <= '0;
    else if (adv) vld_q <= vld_pipe[PIPE_STAGES-1:0];
  end

  // Repack the input. Bubbles carry an all-zero payload so R reads 0 whenever
  // out_valid is low.
  always_comb begin
    n_in = '0;
    if (bus.in_valid) begin
      n_in.tag  = bus.in_tag;
      n_in.fp32 = (bus.fmt == FMT_FP32);
      if (n_in.fp32) begin
        n_in.w                  = {bus.X, 2'b00};
        n_in.sh_f[SHAMT_W-1:0]  = bus.S[SHAMT_W-1:0];
      end else begin
        // Middle bits of X between the two lanes are deliberately dropped.
        n_in.w[WW-1 -: LW2]             = {bus.X[DATA_W-1 -: LANE_W], 2'b00};
        n_in.w[LW2-1:0]                 = {bus.X[LANE_W-1:0], 2'b00};
        n_in.sh_h[LANE_SHAMT_W-1:0]     = bus.S[2*LANE_SHAMT_W-1 -: LANE_SHAMT_W];
        n_in.sh_l[LANE_SHAMT_W-1:0]     = bus.S[LANE_SHAMT_W-1:0];
      end
    end
  end

  assign node[0] = n_in;

  // Stage k shifts by 2^k. Saturation needs no special case: once the
  // accumulated shift reaches the lane width the lane is empty and the masks
  // have already swept every original bit into the sticky.
  for (genvar k = 0; k < K; k++) begin : gen_stg
    localparam int A = 1 << k;
    localparam logic [WW-1:0]  MF = (A >= WW)  ? {WW{1'b1}}  : ~({WW{1'b1}}  << A);
    localparam logic [LW2-1:0] ML = (A >= LW2) ? {LW2{1'b1}} : ~({LW2{1'b1}} << A);

    beat_t          cmb;
    logic [LW2-1:0] hi, lo;

    always_comb begin
      cmb = node[k];
      hi  = node[k].w[WW-1 -: LW2];
      lo  = node[k].w[LW2-1:0];
      if (node[k].fp32) begin
        if (node[k].sh_f[k]) begin
          cmb.st_l = node[k].st_l | (|(node[k].w & MF));
          cmb.w    = node[k].w >> A;
        end
      end else begin
        // Lanes are shifted separately so nothing crosses the gap.
        if (node[k].sh_h[k]) begin
          cmb.st_h = node[k].st_h | (|(hi & ML));
          hi       = hi >> A;
        end
        if (node[k].sh_l[k]) begin
          cmb.st_l = node[k].st_l | (|(lo & ML));
          lo       = lo >> A;
        end
        cmb.w                = '0;
        cmb.w[WW-1 -: LW2]   = hi;
        cmb.w[LW2-1:0]       = lo;
      end
    end

    if (is_rank(k)) begin : gen_rank
      beat_t q;
      always_ff @(posedge clk) begin
        if (rst)      q <= '0;
        else if (adv) q <= cmb;
      end
      assign node[k+1] = q;
    end else begin : gen_pass
      assign node[k+1] = cmb;
    end
  end

  assign bus.out_valid = vld_pipe[PIPE_STAGES];
  assign bus.R         = node[K].w;
  assign bus.Sticky_h  = node[K].st_h;
  assign bus.Sticky_l  = node[K].st_l;
  assign bus.out_tag   = node[K].tag;

endmodule
